bw_io_bsr_seq: RTL and testbench

- Boundary-scan DR sequencer for a chain of CHAIN_LEN CMOS I/O pad bscan cells.
- Accepts one operation at a time from a host on a valid/ready request port: capture+shift, shift-only, update, or mode configure.
- Generates the shift_dr/clock_dr/update_dr strobes and the mode_ctl/hiz_l levels shared by every cell in the chain.
- Serialises host data into bsr_si, collects bso, and returns the captured chain contents on a valid/ready response port.

---
 rtl/bw_io_bsr_pkg.sv | 25 ++
 rtl/bw_io_bsr_shreg.sv | 27 ++
 rtl/bw_io_bsr_seq.sv | 148 ++++++++++++++
 tb/tb_bw_io_bsr_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bw_io_bsr_pkg.sv
// Shared definitions for the boundary-scan DR sequencer: op codes, FSM states
// and the bit positions used by the CFG operation.
package bw_io_bsr_pkg;

  // Host operation encodings carried on req_op
  localparam logic [1:0] BSR_OP_SCAN   = 2'b00;
  localparam logic [1:0] BSR_OP_SHIFT  = 2'b01;
  localparam logic [1:0] BSR_OP_UPDATE = 2'b10;
  localparam logic [1:0] BSR_OP_CFG    = 2'b11;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SHIFT   = 3'd2,
    UPDATE  = 3'd3,
    CFG     = 3'd4,
    DONE    = 3'd5
  } bsr_state_t;

  // Positions of the configuration bits inside req_data for a CFG request
  localparam int CFG_MODE_BIT = 0;
  localparam int CFG_HIZ_BIT  = 1;

endpackage

// File: rtl/bw_io_bsr_shreg.sv
// Host-side image of the scan chain. Loaded with the shift-in pattern when a
// request is accepted; each shift moves one bit towards bit 0 and inserts the
// bit returned from the chain (bso) at the top.
module bw_io_bsr_shreg #(
  parameter int CHAIN_LEN = 16
) (
  input  logic                 clk,
  input  logic                 rst_io_l,
  input  logic                 load,
  input  logic [CHAIN_LEN-1:0] load_data,
  input  logic                 shift_en,
  input  logic                 sin,
  output logic [CHAIN_LEN-1:0] q
);

  // Load has priority; shifting is right-shift with bso entering at the MSB
  always_ff @(posedge clk or negedge rst_io_l) begin
    if (!rst_io_l) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= {sin, q[CHAIN_LEN-1:1]};
    end
  end

endmodule

// File: rtl/bw_io_bsr_seq.sv
// Boundary-scan DR sequencer. Takes one host operation at a time, drives the
// chain-wide strobes and mode levels, serialises data into bsr_si and returns
// the bits collected from bso. Every chain-facing output is registered, so each
// strobe is set on the edge that enters the state it belongs to.
module bw_io_bsr_seq
  import bw_io_bsr_pkg::*;
#(
  parameter int CHAIN_LEN = 16,
  parameter int CNT_W     = 7
) (
  input  logic                 clk,
  input  logic                 rst_io_l,
  input  logic                 req_vld,
  output logic                 req_rdy,
  input  logic [1:0]           req_op,
  input  logic [CHAIN_LEN-1:0] req_data,
  output logic                 rsp_vld,
  input  logic                 rsp_rdy,
  output logic [CHAIN_LEN-1:0] rsp_data,
  output logic                 shift_dr,
  output logic                 clock_dr,
  output logic                 update_dr,
  output logic                 mode_ctl,
  output logic                 hiz_l,
  output logic                 bsr_si,
  input  logic                 bso
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  bsr_state_t           state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 ret_data_reg;   // operation returns the shifted-out bits
  logic [CHAIN_LEN-1:0] shreg_q;
  logic                 accept;
  logic                 shreg_shift;

  assign req_rdy     = (state_reg == IDLE);
  assign accept      = req_rdy && req_vld;
  assign shreg_shift = (state_reg == SHIFT);

  bw_io_bsr_shreg #(
    .CHAIN_LEN (CHAIN_LEN)
  ) u_shreg (
    .clk       (clk),
    .rst_io_l  (rst_io_l),
    .load      (accept),
    .load_data (req_data),
    .shift_en  (shreg_shift),
    .sin       (bso),
    .q         (shreg_q)
  );

  // Sequencer FSM with registered strobes, levels and response
  always_ff @(posedge clk or negedge rst_io_l) begin
    if (!rst_io_l) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      ret_data_reg <= 1'b0;
      shift_dr     <= 1'b0;
      clock_dr     <= 1'b0;
      update_dr    <= 1'b0;
      bsr_si       <= 1'b0;
      mode_ctl     <= 1'b0;
      hiz_l        <= 1'b0;
      rsp_vld      <= 1'b0;
      rsp_data     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_vld) begin
            case (req_op)
              BSR_OP_SCAN: begin
                state_reg    <= CAPTURE;
                clock_dr     <= 1'b1;
                shift_dr     <= 1'b0;
                ret_data_reg <= 1'b1;
              end
              BSR_OP_SHIFT: begin
                state_reg    <= SHIFT;
                clock_dr     <= 1'b1;
                shift_dr     <= 1'b1;
                // shreg is being loaded this edge, so take bit 0 straight from the request
                bsr_si       <= req_data[0];
                cnt_reg      <= '0;
                ret_data_reg <= 1'b1;
              end
              BSR_OP_UPDATE: begin
                state_reg    <= UPDATE;
                update_dr    <= 1'b1;
                ret_data_reg <= 1'b0;
              end
              default: begin
                state_reg    <= CFG;
                mode_ctl     <= req_data[CFG_MODE_BIT];
                hiz_l        <= req_data[CFG_HIZ_BIT];
                ret_data_reg <= 1'b0;
              end
            endcase
          end
        end
        CAPTURE: begin
          state_reg <= SHIFT;
          shift_dr  <= 1'b1;
          clock_dr  <= 1'b1;
          bsr_si    <= shreg_q[0];
          cnt_reg   <= '0;
        end
        SHIFT: begin
          if (cnt_reg == CNT_LAST) begin
            state_reg <= UPDATE;
            shift_dr  <= 1'b0;
            clock_dr  <= 1'b0;
            bsr_si    <= 1'b0;
            update_dr <= 1'b1;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            // shreg moves down one place this edge, so bit 1 is next on bsr_si
            bsr_si  <= shreg_q[1];
          end
        end
        UPDATE: begin
          state_reg <= DONE;
          update_dr <= 1'b0;
          rsp_vld   <= 1'b1;
          rsp_data  <= ret_data_reg ? shreg_q : '0;
        end
        CFG: begin
          state_reg <= DONE;
          rsp_vld   <= 1'b1;
          rsp_data  <= '0;
        end
        DONE: begin
          if (rsp_rdy) begin
            state_reg <= IDLE;
            rsp_vld   <= 1'b0;
            rsp_data  <= '0;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bw_io_bsr_seq.sv
// Bench for bw_io_bsr_seq with a 4-cell chain. The chain is emulated as a
// shift/capture register plus update latches; expected results come from an
// operation-level model of what the chain holds.
module tb_bw_io_bsr_seq;
  import bw_io_bsr_pkg::*;

  localparam int N = 4;
  localparam logic [N-1:0] CAP = 4'b1010;

  logic         clk = 1'b0;
  logic         rst_io_l;
  logic         req_vld;
  logic         req_rdy;
  logic [1:0]   req_op;
  logic [N-1:0] req_data;
  logic         rsp_vld;
  logic         rsp_rdy;
  logic [N-1:0] rsp_data;
  logic         shift_dr, clock_dr, update_dr, mode_ctl, hiz_l, bsr_si, bso;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bw_io_bsr_seq #(.CHAIN_LEN(N), .CNT_W(3)) dut (
    .clk       (clk),
    .rst_io_l  (rst_io_l),
    .req_vld   (req_vld),
    .req_rdy   (req_rdy),
    .req_op    (req_op),
    .req_data  (req_data),
    .rsp_vld   (rsp_vld),
    .rsp_rdy   (rsp_rdy),
    .rsp_data  (rsp_data),
    .shift_dr  (shift_dr),
    .clock_dr  (clock_dr),
    .update_dr (update_dr),
    .mode_ctl  (mode_ctl),
    .hiz_l     (hiz_l),
    .bsr_si    (bsr_si),
    .bso       (bso)
  );

  // Emulated chain: bscan flops clocked by clock_dr, update latches by update_dr
  logic [N-1:0] chain_q = '0;
  logic [N-1:0] upd_q   = '0;
  assign bso = chain_q[0];

  always @(posedge clk) begin
    if (clock_dr) chain_q <= shift_dr ? {bsr_si, chain_q[N-1:1]} : CAP;
    if (update_dr) upd_q <= chain_q;
  end

  // Strobe monitor: running totals, sampled mid-cycle
  int cyc = 0;
  int n_cap = 0, n_sh = 0, n_upd = 0, n_bad = 0;
  logic [N-1:0] si_word = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (clock_dr && !shift_dr) n_cap <= n_cap + 1;
    if (clock_dr && shift_dr) begin
      n_sh    <= n_sh + 1;
      si_word <= {bsr_si, si_word[N-1:1]};
    end
    if (update_dr) n_upd <= n_upd + 1;
    if ((update_dr && clock_dr) || (bsr_si && !(clock_dr && shift_dr)) ||
        (shift_dr && !clock_dr))
      n_bad <= n_bad + 1;
  end

  // Operation-level reference state
  logic [N-1:0] exp_chain = '0;
  logic [N-1:0] exp_upd   = '0;
  logic         exp_mode  = 1'b0;
  logic         exp_hiz   = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete host transaction; entered and left on a negedge
  task automatic do_op(input logic [1:0] op, input logic [N-1:0] d, input int stall);
    logic [N-1:0] exp_rsp;
    int exp_lat, exp_cap, exp_sh, exp_up;
    int c_cap, c_sh, c_up, c_bad, acc, k;
    logic [N-1:0] held;

    case (op)
      BSR_OP_SCAN: begin
        exp_rsp = CAP; exp_lat = N + 3; exp_cap = 1; exp_sh = N; exp_up = 1;
        exp_chain = d; exp_upd = d;
      end
      BSR_OP_SHIFT: begin
        exp_rsp = exp_chain; exp_lat = N + 2; exp_cap = 0; exp_sh = N; exp_up = 1;
        exp_chain = d; exp_upd = d;
      end
      BSR_OP_UPDATE: begin
        exp_rsp = '0; exp_lat = 2; exp_cap = 0; exp_sh = 0; exp_up = 1;
        exp_upd = exp_chain;
      end
      default: begin
        exp_rsp = '0; exp_lat = 2; exp_cap = 0; exp_sh = 0; exp_up = 0;
        exp_mode = d[0]; exp_hiz = d[1];
      end
    endcase

    req_vld = 1'b1; req_op = op; req_data = d;
    k = 0;
    while (!req_rdy && k < 20) begin @(negedge clk); k++; end
    check("req_rdy_idle", req_rdy, 1);
    c_cap = n_cap; c_sh = n_sh; c_up = n_upd; c_bad = n_bad; acc = cyc;
    @(posedge clk); #1;
    req_vld = 1'b0;

    @(negedge clk);
    check("mode_ctl", mode_ctl, exp_mode);
    check("hiz_l", hiz_l, exp_hiz);

    k = 0;
    while (!rsp_vld && k < 40) begin @(negedge clk); k++; end
    check("latency", cyc - acc, exp_lat);
    check("rsp_data", rsp_data, exp_rsp);

    held = rsp_data;
    req_vld = 1'b1; req_op = BSR_OP_UPDATE; req_data = ~d;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_rsp_vld", rsp_vld, 1);
      check("stall_rsp_data", rsp_data, held);
      check("stall_req_rdy", req_rdy, 0);
    end
    req_vld = 1'b0;

    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    rsp_rdy = 1'b0;
    @(negedge clk);
    check("rsp_vld_clear", rsp_vld, 0);
    check("req_rdy_after", req_rdy, 1);

    check("n_capture", n_cap - c_cap, exp_cap);
    check("n_shift", n_sh - c_sh, exp_sh);
    check("n_update", n_upd - c_up, exp_up);
    check("strobe_rules", n_bad - c_bad, 0);
    if (op == BSR_OP_SCAN || op == BSR_OP_SHIFT) check("bsr_si_seq", si_word, d);
    check("upd_latch", upd_q, exp_upd);
    $display("op=%0d data=%b stall=%0d rsp=%b upd=%b mode=%0b hiz=%0b",
             op, d, stall, held, upd_q, mode_ctl, hiz_l);
  endtask

  initial begin
    rst_io_l = 1'b0; req_vld = 1'b0; req_op = 2'b00; req_data = '0; rsp_rdy = 1'b0;
    #1;
    check("rst_req_rdy", req_rdy, 1);
    check("rst_strobes", {shift_dr, clock_dr, update_dr, bsr_si}, 0);
    check("rst_levels", {mode_ctl, hiz_l}, 0);
    check("rst_rsp", {rsp_vld, rsp_data}, 0);
    repeat (2) @(negedge clk);
    rst_io_l = 1'b1;
    @(negedge clk);

    do_op(BSR_OP_CFG,    4'b0011, 0);
    do_op(BSR_OP_SCAN,   4'b0110, 0);
    do_op(BSR_OP_SHIFT,  4'b1111, 0);
    do_op(BSR_OP_SHIFT,  4'b0000, 0);
    do_op(BSR_OP_SCAN,   4'b1001, 10);
    do_op(BSR_OP_UPDATE, 4'b0101, 0);

    // Abort a SHIFT part-way through with an asynchronous reset
    req_vld = 1'b1; req_op = BSR_OP_SHIFT; req_data = 4'b0101;
    @(posedge clk); #1;
    req_vld = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_shift_active", shift_dr && clock_dr, 1);
    #2 rst_io_l = 1'b0;
    #1;
    check("abort_strobes", {shift_dr, clock_dr, update_dr, bsr_si}, 0);
    check("abort_hiz_l", hiz_l, 0);
    check("abort_mode_ctl", mode_ctl, 0);
    check("abort_req_rdy", req_rdy, 1);
    check("abort_rsp_vld", rsp_vld, 0);
    check("abort_upd_latch", upd_q, exp_upd);
    exp_mode = 1'b0; exp_hiz = 1'b0;
    @(negedge clk);
    rst_io_l = 1'b1;
    repeat (2) @(negedge clk);
    check("post_abort_upd", upd_q, exp_upd);
    check("post_abort_strobes", {shift_dr, clock_dr, update_dr}, 0);

    // Chain contents are partially shifted now; a SCAN re-establishes them
    do_op(BSR_OP_SCAN, 4'b0011, 1);

    for (int i = 0; i < 16; i++) begin
      do_op(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
